rob_commit_queue: RTL

- In-order reorder buffer placed directly upstream of the register file.
- Allocates one entry per dispatched instruction and captures results broadcast on the common data bus.
- Retires entries strictly in program order onto the register file's ROBwriteEnable / ROBwriteData / ROBwriteIndex write interface.
- The register file latches on the rising edge of ROBwriteEnable, so every commit must be a clean one-cycle high pulse.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/rob_ptr_ctrl.sv | 46 ++++
 rtl/rob_commit_queue.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the reorder buffer slice.
// Contents:
//   XLEN, REG_IDX_W   - datapath and architectural register index widths
//   ROB_DEPTH/IDX_W   - default reorder buffer geometry
//   commit_state_e    - commit sequencer states (IDLE / PULSE)
//   rob_entry_t       - one reorder buffer slot {busy, ready, rd, data}
package cpu_pkg;
  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int ROB_DEPTH = 8;
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);

  typedef enum logic {
    COMMIT_IDLE  = 1'b0,
    COMMIT_PULSE = 1'b1
  } commit_state_e;

  typedef struct packed {
    logic                 busy;
    logic                 ready;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } rob_entry_t;
endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail pointer pair for the reorder buffer. Each pointer carries an
// extra wrap bit so full and empty can be told apart when the indices match.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   flush        - return both pointers to zero on the next edge
//   push / pop   - advance tail / head by one
//   head / tail  - pointers including wrap bit
//   full, empty  - occupancy flags, derived from the registered pointers
//   count        - tail - head, modular
module rob_ptr_ctrl #(
  parameter int IDX_W = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           push,
  input  logic           pop,
  output logic [IDX_W:0] head,
  output logic [IDX_W:0] tail,
  output logic           full,
  output logic           empty,
  output logic [IDX_W:0] count
);
  logic [IDX_W:0] head_reg;
  logic [IDX_W:0] tail_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else if (flush) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
    end
  end

  assign head  = head_reg;
  assign tail  = tail_reg;
  assign full  = (head_reg[IDX_W] != tail_reg[IDX_W]) &&
                 (head_reg[IDX_W-1:0] == tail_reg[IDX_W-1:0]);
  assign empty = (head_reg == tail_reg);
  assign count = tail_reg - head_reg;
endmodule

// File: rtl/rob_commit_queue.sv
// In-order reorder buffer feeding the register file write port.
// Entries are allocated at dispatch, filled from the common data bus and
// retired in program order, at most one every two cycles so that each
// register-file write is a clean single-cycle pulse.
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   alloc_valid/alloc_rd            - dispatch request and destination reg
//   alloc_ready/alloc_tag           - slot available / tag granted (tail)
//   cdb_valid/cdb_tag/cdb_data      - result broadcast
//   flush                           - discard every in-flight entry
//   rob_write_enable/data/index     - register file commit interface
//   count, empty                    - occupancy
module rob_commit_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int IDX_W = ROB_IDX_W,
  parameter int XLEN  = cpu_pkg::XLEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_valid,
  input  logic [4:0]           alloc_rd,
  output logic                 alloc_ready,
  output logic [IDX_W-1:0]     alloc_tag,
  input  logic                 cdb_valid,
  input  logic [IDX_W-1:0]     cdb_tag,
  input  logic [XLEN-1:0]      cdb_data,
  input  logic                 flush,
  output logic                 rob_write_enable,
  output logic [XLEN-1:0]      rob_write_data,
  output logic [4:0]           rob_write_index,
  output logic [IDX_W:0]       count,
  output logic                 empty
);
  logic [IDX_W:0]   head_ptr;
  logic [IDX_W:0]   tail_ptr;
  logic             full;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic             alloc_fire;
  logic             commit_fire;

  rob_entry_t entries [DEPTH];

  commit_state_e    state_reg, state_next;
  logic             we_reg, we_next;
  logic [XLEN-1:0]  wdata_reg, wdata_next;
  logic [4:0]       widx_reg, widx_next;

  assign head_idx    = head_ptr[IDX_W-1:0];
  assign tail_idx    = tail_ptr[IDX_W-1:0];
  assign alloc_ready = !full;
  assign alloc_tag   = tail_idx;
  // Full is taken from the registered pointers, so a slot freed by a commit
  // only becomes allocatable on the following cycle.
  assign alloc_fire  = alloc_valid && !full && !flush;

  rob_ptr_ctrl #(.IDX_W(IDX_W)) u_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (alloc_fire),
    .pop   (commit_fire),
    .head  (head_ptr),
    .tail  (tail_ptr),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Per-entry state. Update order inside each slot gives allocation
  // precedence over a same-cycle broadcast, and commit clears last.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    rob_entry_t entry_reg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        entry_reg <= '0;
      end else if (flush) begin
        entry_reg.busy  <= 1'b0;
        entry_reg.ready <= 1'b0;
      end else begin
        if (cdb_valid && cdb_tag == IDX_W'(gi) && entry_reg.busy) begin
          entry_reg.data  <= cdb_data;
          entry_reg.ready <= 1'b1;
        end
        if (alloc_fire && tail_idx == IDX_W'(gi)) begin
          entry_reg.busy  <= 1'b1;
          entry_reg.ready <= 1'b0;
          entry_reg.rd    <= alloc_rd;
        end
        if (commit_fire && head_idx == IDX_W'(gi)) begin
          entry_reg.busy  <= 1'b0;
          entry_reg.ready <= 1'b0;
        end
      end
    end

    assign entries[gi] = entry_reg;
  end

  // Commit sequencer: IDLE retires the head when its result has landed,
  // PULSE is the mandatory low cycle after every retirement.
  always_comb begin
    state_next  = state_reg;
    commit_fire = 1'b0;
    we_next     = 1'b0;
    wdata_next  = wdata_reg;
    widx_next   = widx_reg;
    case (state_reg)
      COMMIT_IDLE: begin
        if (!flush && entries[head_idx].busy && entries[head_idx].ready) begin
          commit_fire = 1'b1;
          // x0 retires silently but still updates the data/index outputs.
          we_next     = (entries[head_idx].rd != 5'd0);
          wdata_next  = entries[head_idx].data;
          widx_next   = entries[head_idx].rd;
          state_next  = COMMIT_PULSE;
        end
      end
      COMMIT_PULSE: state_next = COMMIT_IDLE;
      default:      state_next = COMMIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= COMMIT_IDLE;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
      widx_reg  <= '0;
    end else begin
      state_reg <= state_next;
      we_reg    <= we_next;
      wdata_reg <= wdata_next;
      widx_reg  <= widx_next;
    end
  end

  assign rob_write_enable = we_reg;
  assign rob_write_data   = wdata_reg;
  assign rob_write_index  = widx_reg;
endmodule
